// File: rtl/ks_pkg.sv
// ks_pkg: shared constants and per-stage pipeline record for the Kogge-Stone pipelined adder
package ks_pkg;
  localparam int SLICE_W    = 8;
  localparam int NUM_STAGES = 4;
  localparam int DATA_W     = SLICE_W * NUM_STAGES;
  localparam int KS_TAG_W   = 5;
  typedef struct packed {
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
    logic [DATA_W-1:0]   sum;
    logic                carry;
    logic                sub;
    logic [KS_TAG_W-1:0] tag;
    logic                valid;
  } ks_stage_t;
endpackage

// File: rtl/ks8_cin_slice.sv
// ks8_cin_slice: 8-bit Kogge-Stone prefix adder with carry-in, exposing carry into the top bit
module ks8_cin_slice
  import ks_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               cin_i,
  output logic [SLICE_W-1:0] sum_o,
  output logic               cout_o,
  output logic               c7_o
);
  logic [SLICE_W-1:0] p, gk, pk, gn, pn;
  // carry-in is folded into bit 0's generate, then log2(SLICE_W) prefix levels
  always_comb begin
    p  = a_i ^ b_i;
    gk = (a_i & b_i) | {{(SLICE_W-1){1'b0}}, p[0] & cin_i};
    pk = p;
    for (int l = 1; l < SLICE_W; l = l * 2) begin
      gn = gk;
      pn = pk;
      for (int i = l; i < SLICE_W; i++) begin
        gn[i] = gk[i] | (pk[i] & gk[i-l]);
        pn[i] = pk[i] & pk[i-l];
      end
      gk = gn;
      pk = pn;
    end
    sum_o  = p ^ {gk[SLICE_W-2:0], cin_i};
    cout_o = gk[SLICE_W-1];
    c7_o   = gk[SLICE_W-2];
  end
endmodule

// File: rtl/ks_add32_pipe.sv
// ks_add32_pipe: 4-stage elastic 32-bit add/sub, one byte per stage; KS_ADD32_SUB_EN enables subtraction
module ks_add32_pipe
  import ks_pkg::*;
#(
  parameter int TAG_W = KS_TAG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_sub,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_cout,
  output logic              out_ovf,
  output logic [TAG_W-1:0]  out_tag
);
  ks_stage_t st_q [NUM_STAGES];
  ks_stage_t st_d [NUM_STAGES];
  ks_stage_t src  [NUM_STAGES];
  logic [NUM_STAGES-1:0] rdy, co_w, c7_w;
  logic [SLICE_W-1:0] s_w [NUM_STAGES];
  logic [DATA_W-1:0] b_eff;
  logic sub_eff, ovf_q, ovf_d;
`ifdef KS_ADD32_SUB_EN
  assign sub_eff = in_sub;
  assign b_eff   = in_b ^ {DATA_W{in_sub}};
`else
  logic unused_sub;
  assign unused_sub = in_sub;
  assign sub_eff    = 1'b0;
  assign b_eff      = in_b;
`endif
  logic unused_tail;
  assign unused_tail = ^{st_q[NUM_STAGES-1].a, st_q[NUM_STAGES-1].b, st_q[NUM_STAGES-1].sub};
  // backward ready chain: a stage may load if it is empty or its successor can load
  always_comb begin
    rdy[NUM_STAGES-1] = !st_q[NUM_STAGES-1].valid || out_ready;
    for (int k = NUM_STAGES - 2; k >= 0; k--) rdy[k] = !st_q[k].valid || rdy[k+1];
  end
  // operand source per stage: the entry record for stage 0, the previous register otherwise
  always_comb begin
    src[0] = '{a: in_a, b: b_eff, sum: '0, carry: sub_eff, sub: sub_eff,
               tag: KS_TAG_W'(in_tag), valid: in_valid};
    for (int k = 1; k < NUM_STAGES; k++) src[k] = st_q[k-1];
  end
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_slice
    ks8_cin_slice u_slice (
      .a_i   (src[k].a[SLICE_W*k +: SLICE_W]),
      .b_i   (src[k].b[SLICE_W*k +: SLICE_W]),
      .cin_i (src[k].carry),
      .sum_o (s_w[k]),
      .cout_o(co_w[k]),
      .c7_o  (c7_w[k])
    );
  end
  // next record per stage: insert this stage's sum byte and replace the carry with its carry-out
  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      st_d[k] = src[k];
      st_d[k].sum[SLICE_W*k +: SLICE_W] = s_w[k];
      st_d[k].carry = co_w[k];
    end
    ovf_d = c7_w[NUM_STAGES-1] ^ co_w[NUM_STAGES-1];
  end
  // stage registers load whenever their ready is high, which lets bubbles collapse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_STAGES; k++) st_q[k] <= '0;
      ovf_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) if (rdy[k]) st_q[k] <= st_d[k];
      if (rdy[NUM_STAGES-1]) ovf_q <= ovf_d;
    end
  end
  assign in_ready  = rdy[0];
  assign out_valid = st_q[NUM_STAGES-1].valid;
  assign out_sum   = st_q[NUM_STAGES-1].sum;
  assign out_cout  = st_q[NUM_STAGES-1].carry;
  assign out_ovf   = ovf_q;
  assign out_tag   = TAG_W'(st_q[NUM_STAGES-1].tag);
endmodule
